// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Definitions shared by the ID/EX pipeline register and its forwarding logic.
//   fwd_sel_e : ALU operand mux select codes
//                 FWD_REG   - operand comes from the register file read
//                 FWD_EXMEM - operand comes from the EX/MEM ALU result
//                 FWD_MEMWB - operand comes from the MEM/WB writeback value
//   CTRL_*    : bit positions inside the MEM and WB control bundles
// ---------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    localparam int CTRL_MEM_READ      = 0;
    localparam int CTRL_MEM_WRITE     = 1;
    localparam int CTRL_WB_REG_WRITE  = 0;
    localparam int CTRL_WB_MEM_TO_REG = 1;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Signal bundle of the ID/EX pipeline register.
//   pipeline control : enable, stall, flush
//   decode side      : in_valid, in_pc_next, in_reg_a/b, in_imm,
//                      in_rs/rt/rd, in_ctrl_ex/mem/wb
//   forwarding side  : in_exmem_rd/reg_write, in_memwb_rd/reg_write
//   EX side          : out_* registered copies, out_select_a/b, out_load_use
// Modports:
//   master - the environment that drives the stage (decode, hazard unit)
//   slave  - the ID/EX stage itself
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int len_data     = 32,
    parameter int len_addr     = 5,
    parameter int len_ctrl_ex  = 6,
    parameter int len_ctrl_mem = 2,
    parameter int len_ctrl_wb  = 2
);
    logic                    enable;
    logic                    stall;
    logic                    flush;

    logic                    in_valid;
    logic [len_data-1:0]     in_pc_next;
    logic [len_data-1:0]     in_reg_a;
    logic [len_data-1:0]     in_reg_b;
    logic [len_data-1:0]     in_imm;
    logic [len_addr-1:0]     in_rs;
    logic [len_addr-1:0]     in_rt;
    logic [len_addr-1:0]     in_rd;
    logic [len_ctrl_ex-1:0]  in_ctrl_ex;
    logic [len_ctrl_mem-1:0] in_ctrl_mem;
    logic [len_ctrl_wb-1:0]  in_ctrl_wb;

    logic [len_addr-1:0]     in_exmem_rd;
    logic                    in_exmem_reg_write;
    logic [len_addr-1:0]     in_memwb_rd;
    logic                    in_memwb_reg_write;

    logic                    out_valid;
    logic [len_data-1:0]     out_pc_next;
    logic [len_data-1:0]     out_reg_a;
    logic [len_data-1:0]     out_reg_b;
    logic [len_data-1:0]     out_imm;
    logic [len_addr-1:0]     out_rs;
    logic [len_addr-1:0]     out_rt;
    logic [len_addr-1:0]     out_rd;
    logic [len_ctrl_ex-1:0]  out_ctrl_ex;
    logic [len_ctrl_mem-1:0] out_ctrl_mem;
    logic [len_ctrl_wb-1:0]  out_ctrl_wb;
    logic [1:0]              out_select_a;
    logic [1:0]              out_select_b;
    logic                    out_load_use;

    modport master (
        output enable, stall, flush,
        output in_valid, in_pc_next, in_reg_a, in_reg_b, in_imm,
        output in_rs, in_rt, in_rd, in_ctrl_ex, in_ctrl_mem, in_ctrl_wb,
        output in_exmem_rd, in_exmem_reg_write, in_memwb_rd, in_memwb_reg_write,
        input  out_valid, out_pc_next, out_reg_a, out_reg_b, out_imm,
        input  out_rs, out_rt, out_rd, out_ctrl_ex, out_ctrl_mem, out_ctrl_wb,
        input  out_select_a, out_select_b, out_load_use
    );

    modport slave (
        input  enable, stall, flush,
        input  in_valid, in_pc_next, in_reg_a, in_reg_b, in_imm,
        input  in_rs, in_rt, in_rd, in_ctrl_ex, in_ctrl_mem, in_ctrl_wb,
        input  in_exmem_rd, in_exmem_reg_write, in_memwb_rd, in_memwb_reg_write,
        output out_valid, out_pc_next, out_reg_a, out_reg_b, out_imm,
        output out_rs, out_rt, out_rd, out_ctrl_ex, out_ctrl_mem, out_ctrl_wb,
        output out_select_a, out_select_b, out_load_use
    );

endinterface

// File: rtl/id_ex_stage_forwarding_unit.sv
// ---------------------------------------------------------------------------
// forwarding_unit
// Combinational ALU operand forwarding select generation for the EX stage.
//   valid_i             : EX stage holds a real instruction
//   rs_i, rt_i          : source registers of the EX stage instruction
//   exmem_rd_i/_reg_write_i : destination/write enable in EX/MEM
//   memwb_rd_i/_reg_write_i : destination/write enable in MEM/WB
//   select_a_o/_b_o     : fwd_sel_e code for operand A (rs) / B (rt)
// EX/MEM is the younger producer, so it wins when both stages match.
// Register 0 is hardwired to zero and is never forwarded.
// ---------------------------------------------------------------------------
module forwarding_unit
    import mips_pkg::*;
#(
    parameter int len_addr = 5
) (
    input  logic                valid_i,
    input  logic [len_addr-1:0] rs_i,
    input  logic [len_addr-1:0] rt_i,
    input  logic [len_addr-1:0] exmem_rd_i,
    input  logic                exmem_reg_write_i,
    input  logic [len_addr-1:0] memwb_rd_i,
    input  logic                memwb_reg_write_i,
    output logic [1:0]          select_a_o,
    output logic [1:0]          select_b_o
);

    function automatic fwd_sel_e pick(input logic [len_addr-1:0] src);
        fwd_sel_e sel;
        sel = FWD_REG;
        if (valid_i && exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == src))
            sel = FWD_EXMEM;
        else if (valid_i && memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == src))
            sel = FWD_MEMWB;
        return sel;
    endfunction

    always_comb begin
        select_a_o = pick(rs_i);
        select_b_o = pick(rt_i);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the 5-stage MIPS core.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register
//   bus   : id_ex_stage_if.slave
//             enable=0 freezes all state; flush clears everything;
//             stall inserts a bubble (control/valid cleared, data held);
//             otherwise the decode inputs are captured.
//           Also produces the operand forwarding selects and the
//           load-use hazard flag against the instruction in decode.
// ---------------------------------------------------------------------------
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int len_data     = 32,
    parameter int len_addr     = 5,
    parameter int len_ctrl_ex  = 6,
    parameter int len_ctrl_mem = 2,
    parameter int len_ctrl_wb  = 2
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    logic                    valid_q,    valid_d;
    logic [len_data-1:0]     pc_next_q,  pc_next_d;
    logic [len_data-1:0]     reg_a_q,    reg_a_d;
    logic [len_data-1:0]     reg_b_q,    reg_b_d;
    logic [len_data-1:0]     imm_q,      imm_d;
    logic [len_addr-1:0]     rs_q,       rs_d;
    logic [len_addr-1:0]     rt_q,       rt_d;
    logic [len_addr-1:0]     rd_q,       rd_d;
    logic [len_ctrl_ex-1:0]  ctrl_ex_q,  ctrl_ex_d;
    logic [len_ctrl_mem-1:0] ctrl_mem_q, ctrl_mem_d;
    logic [len_ctrl_wb-1:0]  ctrl_wb_q,  ctrl_wb_d;

    // Next-state: flush > stall > load. The enable gate sits on the
    // register itself so a frozen stage keeps whatever it holds, bubble
    // included.
    always_comb begin
        valid_d    = valid_q;
        pc_next_d  = pc_next_q;
        reg_a_d    = reg_a_q;
        reg_b_d    = reg_b_q;
        imm_d      = imm_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        rd_d       = rd_q;
        ctrl_ex_d  = ctrl_ex_q;
        ctrl_mem_d = ctrl_mem_q;
        ctrl_wb_d  = ctrl_wb_q;

        if (bus.flush) begin
            valid_d    = 1'b0;
            pc_next_d  = '0;
            reg_a_d    = '0;
            reg_b_d    = '0;
            imm_d      = '0;
            rs_d       = '0;
            rt_d       = '0;
            rd_d       = '0;
            ctrl_ex_d  = '0;
            ctrl_mem_d = '0;
            ctrl_wb_d  = '0;
        end else if (bus.stall) begin
            // Bubble: kill side effects, keep operands for the replay.
            valid_d    = 1'b0;
            ctrl_ex_d  = '0;
            ctrl_mem_d = '0;
            ctrl_wb_d  = '0;
        end else begin
            valid_d    = bus.in_valid;
            pc_next_d  = bus.in_pc_next;
            reg_a_d    = bus.in_reg_a;
            reg_b_d    = bus.in_reg_b;
            imm_d      = bus.in_imm;
            rs_d       = bus.in_rs;
            rt_d       = bus.in_rt;
            rd_d       = bus.in_rd;
            ctrl_ex_d  = bus.in_ctrl_ex;
            ctrl_mem_d = bus.in_ctrl_mem;
            ctrl_wb_d  = bus.in_ctrl_wb;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            pc_next_q  <= '0;
            reg_a_q    <= '0;
            reg_b_q    <= '0;
            imm_q      <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            ctrl_ex_q  <= '0;
            ctrl_mem_q <= '0;
            ctrl_wb_q  <= '0;
        end else if (bus.enable) begin
            valid_q    <= valid_d;
            pc_next_q  <= pc_next_d;
            reg_a_q    <= reg_a_d;
            reg_b_q    <= reg_b_d;
            imm_q      <= imm_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            rd_q       <= rd_d;
            ctrl_ex_q  <= ctrl_ex_d;
            ctrl_mem_q <= ctrl_mem_d;
            ctrl_wb_q  <= ctrl_wb_d;
        end
    end

    assign bus.out_valid    = valid_q;
    assign bus.out_pc_next  = pc_next_q;
    assign bus.out_reg_a    = reg_a_q;
    assign bus.out_reg_b    = reg_b_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_rs       = rs_q;
    assign bus.out_rt       = rt_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_ctrl_ex  = ctrl_ex_q;
    assign bus.out_ctrl_mem = ctrl_mem_q;
    assign bus.out_ctrl_wb  = ctrl_wb_q;

    forwarding_unit #(
        .len_addr (len_addr)
    ) u_fwd (
        .valid_i           (valid_q),
        .rs_i              (rs_q),
        .rt_i              (rt_q),
        .exmem_rd_i        (bus.in_exmem_rd),
        .exmem_reg_write_i (bus.in_exmem_reg_write),
        .memwb_rd_i        (bus.in_memwb_rd),
        .memwb_reg_write_i (bus.in_memwb_reg_write),
        .select_a_o        (bus.out_select_a),
        .select_b_o        (bus.out_select_b)
    );

    // A load in EX whose target is read by the instruction in decode cannot
    // be covered by forwarding; the hazard unit answers with a one-cycle stall.
    assign bus.out_load_use = valid_q && ctrl_mem_q[CTRL_MEM_READ] && (rt_q != '0) &&
                              bus.in_valid && ((rt_q == bus.in_rs) || (rt_q == bus.in_rt));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic clk;
    logic reset;

    id_ex_stage_if #(.len_data(32), .len_addr(5), .len_ctrl_ex(6), .len_ctrl_mem(2), .len_ctrl_wb(2)) bus ();

    id_ex_stage #(.len_data(32), .len_addr(5), .len_ctrl_ex(6), .len_ctrl_mem(2), .len_ctrl_wb(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en, stall, flush, vld;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a;
        logic [5:0]  cex;
        logic [1:0]  cmem, cwb;
        logic [4:0]  xrd;
        logic        xwe;
        logic [4:0]  wrd;
        logic        wwe;
    } stim_t;

    typedef struct {
        logic        vld;
        logic [31:0] a;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  cex;
        logic [1:0]  cmem, cwb, sa, sb;
        logic        lu;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    exp_t sb_q [$];

    int n_vec = 0;
    int n_err = 0;

    // Other data inputs are tied to reg_a so their expected value follows
    // the expected reg_a (zero stays zero after a flush or reset).
    function automatic logic [31:0] f_b(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0 : a + 32'h100;
    endfunction
    function automatic logic [31:0] f_imm(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0 : ~a;
    endfunction
    function automatic logic [31:0] f_pc(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0 : {a[29:0], 2'b00};
    endfunction

    function automatic stim_t st(input logic en, stall, flush, vld,
                                 input logic [4:0] rs, rt, rd, input logic [31:0] a,
                                 input logic [5:0] cex, input logic [1:0] cmem, cwb,
                                 input logic [4:0] xrd, input logic xwe,
                                 input logic [4:0] wrd, input logic wwe);
        stim_t s;
        s.en = en; s.stall = stall; s.flush = flush; s.vld = vld;
        s.rs = rs; s.rt = rt; s.rd = rd; s.a = a;
        s.cex = cex; s.cmem = cmem; s.cwb = cwb;
        s.xrd = xrd; s.xwe = xwe; s.wrd = wrd; s.wwe = wwe;
        return s;
    endfunction

    function automatic exp_t ex(input logic vld, input logic [31:0] a,
                                input logic [4:0] rs, rt, rd, input logic [5:0] cex,
                                input logic [1:0] cmem, cwb, sa, sb, input logic lu);
        exp_t e;
        e.vld = vld; e.a = a; e.rs = rs; e.rt = rt; e.rd = rd;
        e.cex = cex; e.cmem = cmem; e.cwb = cwb; e.sa = sa; e.sb = sb; e.lu = lu;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply(input stim_t s);
        bus.enable             = s.en;
        bus.stall              = s.stall;
        bus.flush              = s.flush;
        bus.in_valid           = s.vld;
        bus.in_rs              = s.rs;
        bus.in_rt              = s.rt;
        bus.in_rd              = s.rd;
        bus.in_reg_a           = s.a;
        bus.in_reg_b           = f_b(s.a);
        bus.in_imm             = f_imm(s.a);
        bus.in_pc_next         = f_pc(s.a);
        bus.in_ctrl_ex         = s.cex;
        bus.in_ctrl_mem        = s.cmem;
        bus.in_ctrl_wb         = s.cwb;
        bus.in_exmem_rd        = s.xrd;
        bus.in_exmem_reg_write = s.xwe;
        bus.in_memwb_rd        = s.wrd;
        bus.in_memwb_reg_write = s.wwe;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".valid"},    32'(bus.out_valid),    32'(e.vld));
        chk({tag, ".reg_a"},    bus.out_reg_a,         e.a);
        chk({tag, ".reg_b"},    bus.out_reg_b,         f_b(e.a));
        chk({tag, ".imm"},      bus.out_imm,           f_imm(e.a));
        chk({tag, ".pc_next"},  bus.out_pc_next,       f_pc(e.a));
        chk({tag, ".rs"},       32'(bus.out_rs),       32'(e.rs));
        chk({tag, ".rt"},       32'(bus.out_rt),       32'(e.rt));
        chk({tag, ".rd"},       32'(bus.out_rd),       32'(e.rd));
        chk({tag, ".ctrl_ex"},  32'(bus.out_ctrl_ex),  32'(e.cex));
        chk({tag, ".ctrl_mem"}, 32'(bus.out_ctrl_mem), 32'(e.cmem));
        chk({tag, ".ctrl_wb"},  32'(bus.out_ctrl_wb),  32'(e.cwb));
        chk({tag, ".sel_a"},    32'(bus.out_select_a), 32'(e.sa));
        chk({tag, ".sel_b"},    32'(bus.out_select_b), 32'(e.sb));
        chk({tag, ".load_use"}, 32'(bus.out_load_use), 32'(e.lu));
    endtask

    exp_t e_cur;
    exp_t e_zero;
    exp_t e_ones;

    initial begin
        //               en st fl v  rs rt rd a          cex    cm cw xrd xwe wrd wwe
        // add-like loads exercising the forwarding selects
        tbl[0]  = '{st(1, 0, 0, 1, 3, 4, 5, 32'h11,   6'h21, 0, 1, 3, 1, 3, 1), ex(1, 32'h11,   3, 4, 5, 6'h21, 0, 1, 1, 0, 0)};
        tbl[1]  = '{st(1, 0, 0, 1, 3, 4, 5, 32'h12,   6'h21, 0, 1, 3, 0, 3, 1), ex(1, 32'h12,   3, 4, 5, 6'h21, 0, 1, 2, 0, 0)};
        tbl[2]  = '{st(1, 0, 0, 1, 0, 4, 5, 32'h13,   6'h21, 0, 1, 0, 1, 0, 1), ex(1, 32'h13,   0, 4, 5, 6'h21, 0, 1, 0, 0, 0)};
        tbl[3]  = '{st(1, 0, 0, 1, 7, 9, 5, 32'h14,   6'h22, 0, 1, 7, 1, 9, 1), ex(1, 32'h14,   7, 9, 5, 6'h22, 0, 1, 1, 2, 0)};
        // add r1 then sub r1,r1: both operands from EX/MEM even with MEM/WB match
        tbl[4]  = '{st(1, 0, 0, 1, 2, 3, 1, 32'h15,   6'h20, 0, 1, 0, 0, 0, 0), ex(1, 32'h15,   2, 3, 1, 6'h20, 0, 1, 0, 0, 0)};
        tbl[5]  = '{st(1, 0, 0, 1, 1, 1, 4, 32'h16,   6'h22, 0, 1, 1, 1, 1, 1), ex(1, 32'h16,   1, 1, 4, 6'h22, 0, 1, 1, 1, 0)};
        // lw rt=8 (its own rt in decode already matches)
        tbl[6]  = '{st(1, 0, 0, 1, 2, 8, 0, 32'h55,   6'h03, 1, 3, 0, 0, 0, 0), ex(1, 32'h55,   2, 8, 0, 6'h03, 1, 3, 0, 0, 1)};
        // stall bubble: control cleared, operands held, no forwarding while invalid
        tbl[7]  = '{st(1, 1, 0, 1, 8, 6, 10, 32'h99,  6'h21, 0, 1, 2, 1, 8, 1), ex(0, 32'h55,   2, 8, 0, 6'h00, 0, 0, 0, 0, 0)};
        tbl[8]  = '{st(1, 0, 0, 1, 8, 6, 10, 32'h99,  6'h21, 0, 1, 0, 0, 0, 0), ex(1, 32'h99,   8, 6, 10, 6'h21, 0, 1, 0, 0, 0)};
        // flush with stall: flush wins, data cleared too
        tbl[9]  = '{st(1, 1, 1, 1, 9, 9, 9, 32'h1234, 6'h3f, 3, 3, 9, 1, 9, 1), ex(0, 32'h0,    0, 0, 0, 6'h00, 0, 0, 0, 0, 0)};
        // mem_write only: no load-use even though rt matches
        tbl[10] = '{st(1, 0, 0, 1, 4, 5, 6, 32'h77,   6'h3f, 2, 3, 5, 1, 4, 1), ex(1, 32'h77,   4, 5, 6, 6'h3f, 2, 3, 2, 1, 0)};
        // frozen three cycles with flush/stall/data wiggling
        tbl[11] = '{st(0, 0, 0, 1, 1, 1, 1, 32'haaa,  6'h01, 1, 1, 5, 1, 4, 1), ex(1, 32'h77,   4, 5, 6, 6'h3f, 2, 3, 2, 1, 0)};
        tbl[12] = '{st(0, 1, 1, 0, 2, 2, 2, 32'hbbb,  6'h02, 1, 1, 5, 1, 4, 1), ex(1, 32'h77,   4, 5, 6, 6'h3f, 2, 3, 2, 1, 0)};
        tbl[13] = '{st(0, 1, 0, 1, 3, 3, 3, 32'hccc,  6'h03, 1, 1, 5, 1, 4, 1), ex(1, 32'h77,   4, 5, 6, 6'h3f, 2, 3, 2, 1, 0)};
        tbl[14] = '{st(1, 0, 0, 1, 1, 2, 3, 32'hbeef, 6'h11, 0, 1, 0, 0, 2, 1), ex(1, 32'hbeef, 1, 2, 3, 6'h11, 0, 1, 0, 2, 0)};
        // stall then freeze: bubble is held
        tbl[15] = '{st(1, 1, 0, 1, 5, 5, 5, 32'hdead, 6'h3f, 3, 3, 0, 0, 2, 1), ex(0, 32'hbeef, 1, 2, 3, 6'h00, 0, 0, 0, 0, 0)};
        tbl[16] = '{st(0, 0, 0, 1, 6, 6, 6, 32'hf00d, 6'h3f, 3, 3, 1, 1, 2, 1), ex(0, 32'hbeef, 1, 2, 3, 6'h00, 0, 0, 0, 0, 0)};
        tbl[17] = '{st(1, 0, 1, 1, 7, 7, 7, 32'h777,  6'h3f, 3, 3, 0, 0, 0, 0), ex(0, 32'h0,    0, 0, 0, 6'h00, 0, 0, 0, 0, 0)};

        e_zero = ex(0, 32'h0, 0, 0, 0, 6'h00, 0, 0, 0, 0, 0);

        // ---- power-on reset ----
        reset = 1'b1;
        apply(st(1, 0, 0, 0, 0, 0, 0, 32'h0, 6'h00, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1 check_all("reset", e_zero);
        @(negedge clk);
        reset = 1'b0;

        // ---- table ----
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(tbl[i].s);
            sb_q.push_back(tbl[i].e);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_empty: got 0 entries expected 1 (row %0d)", i);
            end else begin
                e_cur = sb_q.pop_front();
                check_all($sformatf("row%0d", i), e_cur);
            end
            if (i == 6) begin
                // lw rt=8 in EX, decode now reads r8 as rs
                bus.in_rs = 5'd8;
                bus.in_rt = 5'd6;
                #1 chk("lu_rs_match", 32'(bus.out_load_use), 32'd1);
                bus.in_valid = 1'b0;
                #1 chk("lu_decode_invalid", 32'(bus.out_load_use), 32'd0);
                bus.in_valid = 1'b1;
                bus.in_rs    = 5'd7;
                #1 chk("lu_no_match", 32'(bus.out_load_use), 32'd0);
            end
        end

        // ---- reset mid-run with all inputs high ----
        @(negedge clk);
        bus.enable             = 1'b1;
        bus.stall              = 1'b0;
        bus.flush              = 1'b0;
        bus.in_valid           = 1'b1;
        bus.in_pc_next         = '1;
        bus.in_reg_a           = '1;
        bus.in_reg_b           = '1;
        bus.in_imm             = '1;
        bus.in_rs              = '1;
        bus.in_rt              = '1;
        bus.in_rd              = '1;
        bus.in_ctrl_ex         = '1;
        bus.in_ctrl_mem        = '1;
        bus.in_ctrl_wb         = '1;
        bus.in_exmem_rd        = '1;
        bus.in_exmem_reg_write = 1'b1;
        bus.in_memwb_rd        = '1;
        bus.in_memwb_reg_write = 1'b1;
        @(posedge clk);
        #1;
        chk("ones.valid", 32'(bus.out_valid),    32'd1);
        chk("ones.reg_a", bus.out_reg_a,         32'hffffffff);
        chk("ones.sel_a", 32'(bus.out_select_a), 32'd1);
        chk("ones.lu",    32'(bus.out_load_use), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst.valid",    32'(bus.out_valid),    32'd0);
        chk("async_rst.reg_a",    bus.out_reg_a,         32'd0);
        chk("async_rst.reg_b",    bus.out_reg_b,         32'd0);
        chk("async_rst.imm",      bus.out_imm,           32'd0);
        chk("async_rst.pc_next",  bus.out_pc_next,       32'd0);
        chk("async_rst.rs",       32'(bus.out_rs),       32'd0);
        chk("async_rst.rt",       32'(bus.out_rt),       32'd0);
        chk("async_rst.rd",       32'(bus.out_rd),       32'd0);
        chk("async_rst.ctrl_ex",  32'(bus.out_ctrl_ex),  32'd0);
        chk("async_rst.ctrl_mem", 32'(bus.out_ctrl_mem), 32'd0);
        chk("async_rst.ctrl_wb",  32'(bus.out_ctrl_wb),  32'd0);
        chk("async_rst.sel_a",    32'(bus.out_select_a), 32'd0);
        chk("async_rst.sel_b",    32'(bus.out_select_b), 32'd0);
        chk("async_rst.lu",       32'(bus.out_load_use), 32'd0);
        @(posedge clk);
        #1 chk("rst_held.valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst.valid",    32'(bus.out_valid),    32'd1);
        chk("post_rst.reg_a",    bus.out_reg_a,         32'hffffffff);
        chk("post_rst.imm",      bus.out_imm,           32'hffffffff);
        chk("post_rst.rt",       32'(bus.out_rt),       32'd31);
        chk("post_rst.ctrl_ex",  32'(bus.out_ctrl_ex),  32'h3f);
        chk("post_rst.sel_a",    32'(bus.out_select_a), 32'd1);
        chk("post_rst.sel_b",    32'(bus.out_select_b), 32'd1);
        chk("post_rst.lu",       32'(bus.out_load_use), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
